// File: rtl/dma_ctrl_reg_file.sv
// Control/status register file for the DMA controller: per-BD pending starts, sticky done/err (W1C), IRQ mask.
// Optional ERR register and error interrupt source enabled by defining DMA_CTRL_ERR_STATUS_EN.
module dma_ctrl_reg_file #(
    parameter logic [7:0] MAJOR_VER_NUM = 8'd0,
    parameter logic [7:0] MINOR_VER_NUM = 8'd0,
    parameter logic [7:0] BUILD_NUM     = 8'd0,
    parameter int         NUM_INT_BDS   = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ctrlSel,
    input  logic                   ctrlWr,
    input  logic [10:0]            ctrlAddr,
    input  logic [31:0]            ctrlWrData,
    input  logic [3:0]             ctrlWrStrbs,
    output logic [31:0]            ctrlRdData,
    output logic                   ctrlRdValid,
    output logic [NUM_INT_BDS-1:0] startDMAOp,
    input  logic [NUM_INT_BDS-1:0] startAck,
    input  logic [NUM_INT_BDS-1:0] opDone,
    input  logic [NUM_INT_BDS-1:0] opErr,
    output logic                   irq
);
    localparam int         N      = NUM_INT_BDS;
    localparam logic [7:0] NBDS_8 = 8'(NUM_INT_BDS);

    localparam logic [10:0] A_VER     = 11'h000;
    localparam logic [10:0] A_START   = 11'h004;
    localparam logic [10:0] A_PENDING = 11'h008;
    localparam logic [10:0] A_DONE    = 11'h00C;
    localparam logic [10:0] A_IRQ_EN  = 11'h010;
    localparam logic [10:0] A_ERR     = 11'h014;
    localparam logic [10:0] A_CFG     = 11'h018;

    logic         wr, rd;
    logic [N-1:0] wbits, wmask;
    logic [N-1:0] pending, done, ien, err;
    logic [31:0]  rd_word;
    logic         unused_in;

    assign wr        = ctrlSel & ctrlWr;
    assign rd        = ctrlSel & ~ctrlWr;
    assign unused_in = ^{ctrlWrData, ctrlWrStrbs};
    assign startDMAOp = pending;

    // Unstrobed lanes contribute zeros, so they neither set nor clear anything.
    always_comb begin
        wbits = '0;
        wmask = '0;
        for (int i = 0; i < N; i++) begin
            wmask[i] = ctrlWrStrbs[i/8];
            wbits[i] = ctrlWrData[i] & ctrlWrStrbs[i/8];
        end
    end

    // Set terms are OR'd in last so a new request / hardware event beats a same-cycle clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
            done    <= '0;
            ien     <= '0;
        end else begin
            pending <= (pending & ~startAck) | ((wr && ctrlAddr == A_START) ? wbits : '0);
            done    <= (done & ~((wr && ctrlAddr == A_DONE) ? wbits : '0)) | opDone;
            if (wr && ctrlAddr == A_IRQ_EN)
                ien <= (ien & ~wmask) | wbits;
        end
    end

`ifdef DMA_CTRL_ERR_STATUS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            err <= '0;
        else
            err <= (err & ~((wr && ctrlAddr == A_ERR) ? wbits : '0)) | opErr;
    end
`else
    logic unused_err;
    assign unused_err = ^opErr;
    assign err        = '0;
`endif

    always_comb begin
        rd_word = '0;
        case (ctrlAddr)
            A_VER:     rd_word = {8'h0, MAJOR_VER_NUM, MINOR_VER_NUM, BUILD_NUM};
            A_PENDING: rd_word[N-1:0] = pending;
            A_DONE:    rd_word[N-1:0] = done;
            A_IRQ_EN:  rd_word[N-1:0] = ien;
`ifdef DMA_CTRL_ERR_STATUS_EN
            A_ERR:     rd_word[N-1:0] = err;
`endif
            A_CFG:     rd_word = {24'h0, NBDS_8};
            default:   rd_word = '0;
        endcase
    end

    // Read data captures pre-update state; it holds between reads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrlRdData  <= '0;
            ctrlRdValid <= 1'b0;
            irq         <= 1'b0;
        end else begin
            ctrlRdValid <= rd;
            if (rd)
                ctrlRdData <= rd_word;
            irq <= (|(done & ien)) | (|(err & ien));
        end
    end
endmodule

// File: doc/dma_ctrl_reg_file.md
# dma_ctrl_reg_file

Parametrised control/status register file for the AXI4 DMA controller, sitting between the control-interface CDC mux and the DMA controller core. It replaces the single-cycle start-pulse scheme with per-buffer-descriptor (BD) pending start requests held until the core acknowledges them. It adds sticky completion status with write-1-to-clear, an interrupt enable mask, a registered read path, and a level interrupt output.

## Interface
- MAJOR_VER_NUM, 0, major version, 8 bits
- MINOR_VER_NUM, 0, minor version, 8 bits
- BUILD_NUM, 0, build number, 8 bits
- NUM_INT_BDS, 4, number of internal BDs/channels, legal range 1..32

One clock; reset is asynchronous and active-high.
- clock  input  1  single clock domain
- reset  input  1  asynchronous, active-high reset
- ctrlSel  input  1  access select
- ctrlWr  input  1  1 = write, 0 = read (qualified by ctrlSel)
- ctrlAddr  input  11  byte address
- ctrlWrData  input  32  write data
- ctrlWrStrbs  input  4  byte-lane write strobes
- ctrlRdData  output  32  registered read data
- ctrlRdValid  output  1  one-cycle read-data-valid pulse
- startDMAOp  output  NUM_INT_BDS  per-BD pending start request (level)
- startAck  input  NUM_INT_BDS  per-BD one-cycle acknowledge from core
- opDone  input  NUM_INT_BDS  per-BD one-cycle completion pulse
- opErr  input  NUM_INT_BDS  per-BD one-cycle error pulse
- irq  output  1  registered level interrupt

## Operation
- Register map. Bits at or above NUM_INT_BDS read 0 and ignore writes.
  - 0x000 VER: RO, {8'h0, MAJOR, MINOR, BUILD}.
  - 0x004 START_OP: WO, reads 0. A 1 in bit i sets pending[i].
  - 0x008 PENDING: RO, pending[N-1:0].
  - 0x00C DONE: RW1C, sticky done[N-1:0].
  - 0x010 IRQ_EN: RW, ien[N-1:0].
  - 0x014 ERR: RW1C, sticky err[N-1:0]. Present only with the macro.
  - 0x018 CFG: RO, {24'h0, NUM_INT_BDS[7:0]}.
- Unmapped addresses read 0. Writes to unmapped addresses are ignored.
- Write = ctrlSel & ctrlWr. Only bytes with the strobe set take effect. Unstrobed lanes of START_OP, DONE and ERR act as zeros, i.e. no set and no clear.
- startDMAOp = pending.
  - pending[i] set by a START_OP write bit.
  - pending[i] cleared by startAck[i].
  - Simultaneous set and ack: pending stays 1 (new request wins).
  - A set while already pending is absorbed (no queueing).
  - startAck[i] while pending[i]=0 is ignored.
- done[i] set by opDone[i], cleared by writing 1 to DONE bit i. Simultaneous opDone and W1C: done stays 1 (hardware wins).
- err[i] follows the same rules as done, using opErr and the ERR register.
- irq next = |(done & ien) | |(err & ien).

## Timing
- All outputs are 0 during and after reset: ctrlRdData, ctrlRdValid, startDMAOp, irq, plus pending/done/ien/err.
- Write accepted at clock edge t. Register update is visible on outputs after edge t (startDMAOp high from t+1).
- Read:
  - ctrlSel & !ctrlWr at edge t gives ctrlRdData and ctrlRdValid=1 during the cycle after t.
  - ctrlRdValid deasserts the following cycle unless another read occurs.
  - Back-to-back reads give one valid per cycle.
  - ctrlRdData holds its last value when not valid.
- Read/update ordering: read data samples register state before the same-edge update (old value).
- irq lags the status/enable change by 1 cycle: status set at edge t, irq high after edge t+1.
- Reset asserted mid-operation clears all pending requests immediately. The core must treat a startDMAOp drop without ack as a cancel.

## Configuration
- Macro DMA_CTRL_ERR_STATUS_EN.
- Defined: ERR register at 0x014 exists, opErr is sampled, and err contributes to irq.
- Undefined: no err storage; 0x014 reads 0 and ignores writes; opErr is unused; irq = |(done & ien).

## Test plan
- Reset, then read 0x000 with MAJOR=1, MINOR=2, BUILD=3 -> ctrlRdData=32'h00010203 with ctrlRdValid one cycle after the read; read 0x018 -> 32'h4.
- Write 0x004=32'h5, strobes 4'hF -> startDMAOp=4'b0101 next cycle. Pulse startAck[0] -> 4'b0100. Write 0x004 bit 2 in the same cycle as startAck[2] -> bit 2 stays 1.
- Write 0x004=32'h0000_0F00, strobes 4'h1 -> startDMAOp unchanged (lane 1 unstrobed).
- Write IRQ_EN=4'h2, pulse opDone[1] -> DONE reads 4'h2 and irq=1 two cycles after the pulse. Write 0x00C=4'h2 in the same cycle as a new opDone[1] -> DONE stays 4'h2. Next W1C alone -> DONE=0 and irq drops.
- With the macro: pulse opErr[3], IRQ_EN=4'h8 -> ERR=4'h8, irq=1. Without the macro -> 0x014 reads 0 and irq stays 0.
- Set pending=4'hF, then assert reset for 1 cycle -> startDMAOp=0 immediately and all registers read 0 after release.
